// File: rtl/micro_sequencer_if.sv
// Bus between the micro_sequencer (master) and the program store / accumulator datapath (slave).
// Step exists only when SEQ_STEP_EN is defined.
interface micro_sequencer_if;
   logic       Run;
   logic [7:0] Instr;
`ifdef SEQ_STEP_EN
   logic       Step;
`endif
   logic [3:0] Pc;
   logic [3:0] Imm;
   logic       DataSel;
   logic [1:0] AluOp;
   logic       LatchA;
   logic       LatchB;
   logic       ClearA;
   logic       ClearB;
   logic       LatchOut;
   logic       Halted;
   logic       IllegalOp;

   modport master (
`ifdef SEQ_STEP_EN
      input  Step,
`endif
      input  Run, Instr,
      output Pc, Imm, DataSel, AluOp, LatchA, LatchB, ClearA, ClearB,
      output LatchOut, Halted, IllegalOp
   );

   modport slave (
`ifdef SEQ_STEP_EN
      output Step,
`endif
      output Run, Instr,
      input  Pc, Imm, DataSel, AluOp, LatchA, LatchB, ClearA, ClearB,
      input  LatchOut, Halted, IllegalOp
   );
endinterface

// File: rtl/micro_sequencer.sv
// Fetch/decode/execute control sequencer for the 4-bit micro; SEQ_STEP_EN adds Step and a WAIT state.
//
// state   | meaning
// IDLE    | stopped, waiting for Run
// FETCH   | Pc drives the store, instruction captured at end of cycle
// DECODE  | Imm/AluOp/DataSel valid, Pc incremented at end of cycle
// EXECUTE | the single strobe for the opcode is high
// HALT    | frozen until Clear
// WAIT    | parked between instructions until Step (SEQ_STEP_EN only)
module micro_sequencer (
   input  logic              MainClock,
   input  logic              Clear,
   micro_sequencer_if.master bus
);
   typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXECUTE, HALT, WAIT} seqState_t;

   localparam logic [3:0] OpNop = 4'h0, OpLda = 4'h1, OpLdb = 4'h2, OpAdd = 4'h3;
   localparam logic [3:0] OpSub = 4'h4, OpAnd = 4'h5, OpOr  = 4'h6, OpClra = 4'h7;
   localparam logic [3:0] OpClrb = 4'h8, OpMva = 4'h9, OpJmp = 4'hA, OpHlt = 4'hF;

   seqState_t  state, stateNext;
   logic [3:0] pcReg, pcNext;
   logic [7:0] irReg, irNext;
   logic [3:0] immReg, immNext;
   logic       dataSelReg, dataSelNext;
   logic [1:0] aluOpReg, aluOpNext;
   logic       latchAReg, latchANext, latchBReg, latchBNext;
   logic       clearAReg, clearANext, clearBReg, clearBNext;
   logic       latchOutReg, latchOutNext, illegalOpReg, illegalOpNext;
   logic       haltedReg, haltedNext;

   always_ff @(posedge MainClock) begin
      if (Clear) begin
         state        <= IDLE;
         pcReg        <= 4'd0;
         irReg        <= 8'd0;
         immReg       <= 4'd0;
         dataSelReg   <= 1'b0;
         aluOpReg     <= 2'b00;
         latchAReg    <= 1'b0;
         latchBReg    <= 1'b0;
         clearAReg    <= 1'b0;
         clearBReg    <= 1'b0;
         latchOutReg  <= 1'b0;
         illegalOpReg <= 1'b0;
         haltedReg    <= 1'b0;
      end else begin
         state        <= stateNext;
         pcReg        <= pcNext;
         irReg        <= irNext;
         immReg       <= immNext;
         dataSelReg   <= dataSelNext;
         aluOpReg     <= aluOpNext;
         latchAReg    <= latchANext;
         latchBReg    <= latchBNext;
         clearAReg    <= clearANext;
         clearBReg    <= clearBNext;
         latchOutReg  <= latchOutNext;
         illegalOpReg <= illegalOpNext;
         haltedReg    <= haltedNext;
      end
   end

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:    if (bus.Run) stateNext = FETCH;
         FETCH:   stateNext = DECODE;
         DECODE:  stateNext = EXECUTE;
         EXECUTE: begin
            if (irReg[7:4] == OpHlt) stateNext = HALT;
`ifdef SEQ_STEP_EN
            else                     stateNext = WAIT;
`else
            else                     stateNext = bus.Run ? FETCH : IDLE;
`endif
         end
         HALT:    stateNext = HALT;
`ifdef SEQ_STEP_EN
         WAIT: begin
            if (!bus.Run)     stateNext = IDLE;
            else if (bus.Step) stateNext = FETCH;
         end
`endif
         default: stateNext = IDLE;
      endcase
   end

   // Outputs are registered, so this block computes their values for the next cycle:
   // decode fields are captured with the instruction so they are already valid in DECODE.
   always_comb begin
      pcNext        = pcReg;
      irNext        = irReg;
      immNext       = immReg;
      dataSelNext   = dataSelReg;
      aluOpNext     = aluOpReg;
      latchANext    = 1'b0;
      latchBNext    = 1'b0;
      clearANext    = 1'b0;
      clearBNext    = 1'b0;
      latchOutNext  = 1'b0;
      illegalOpNext = 1'b0;
      haltedNext    = haltedReg;
      case (state)
         FETCH: begin
            irNext      = bus.Instr;
            immNext     = bus.Instr[3:0];
            dataSelNext = (bus.Instr[7:4] == OpMva);
            case (bus.Instr[7:4])
               OpSub:   aluOpNext = 2'b01;
               OpAnd:   aluOpNext = 2'b10;
               OpOr:    aluOpNext = 2'b11;
               default: aluOpNext = 2'b00;
            endcase
         end
         DECODE: begin
            pcNext = pcReg + 4'd1;
            case (irReg[7:4])
               OpLda, OpMva:               latchANext    = 1'b1;
               OpLdb:                      latchBNext    = 1'b1;
               OpAdd, OpSub, OpAnd, OpOr:  latchOutNext  = 1'b1;
               OpClra:                     clearANext    = 1'b1;
               OpClrb:                     clearBNext    = 1'b1;
               OpHlt:                      haltedNext    = 1'b1;
               OpNop, OpJmp:               ;
               default:                    illegalOpNext = 1'b1;
            endcase
         end
         EXECUTE: if (irReg[7:4] == OpJmp) pcNext = irReg[3:0];
         default: ;
      endcase
   end

   assign bus.Pc        = pcReg;
   assign bus.Imm       = immReg;
   assign bus.DataSel   = dataSelReg;
   assign bus.AluOp     = aluOpReg;
   assign bus.LatchA    = latchAReg;
   assign bus.LatchB    = latchBReg;
   // Clear also clears the accumulators in the same cycle, before any edge.
   assign bus.ClearA    = clearAReg | Clear;
   assign bus.ClearB    = clearBReg | Clear;
   assign bus.LatchOut  = latchOutReg;
   assign bus.IllegalOp = illegalOpReg;
   assign bus.Halted    = haltedReg;
endmodule

// File: tb/tb_micro_sequencer.sv
// Bench for micro_sequencer: instruction-level reference model checked every cycle, plus
// directed programs with hand-computed cycle/value expectations.
module tb_micro_sequencer;
   logic       MainClock = 1'b0;
   logic       Clear = 1'b1;
   logic [7:0] prog [16];
   int         tests = 0;
   int         fails = 0;
   int         cur = 0;
   logic       checkEn = 1'b0;

   micro_sequencer_if seqBus();
   micro_sequencer dut (.MainClock(MainClock), .Clear(Clear), .bus(seqBus));

   always #5 MainClock = ~MainClock;
   assign seqBus.Instr = prog[seqBus.Pc];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      tests++;
      if (actual !== expected) begin
         fails++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, actual, expected, $time);
      end
   endtask

   // {LatchA, LatchB, ClearA, ClearB, LatchOut, IllegalOp} for the EXECUTE cycle of each opcode
   function automatic logic [5:0] strobeFor(input logic [3:0] op);
      case (op)
         4'h1, 4'h9:             return 6'b100000;
         4'h2:                   return 6'b010000;
         4'h3, 4'h4, 4'h5, 4'h6: return 6'b000010;
         4'h7:                   return 6'b001000;
         4'h8:                   return 6'b000100;
         4'hB, 4'hC, 4'hD, 4'hE: return 6'b000001;
         default:                return 6'b000000;
      endcase
   endfunction

   function automatic logic [1:0] aluFor(input logic [3:0] op);
      case (op)
         4'h4:    return 2'b01;
         4'h5:    return 2'b10;
         4'h6:    return 2'b11;
         default: return 2'b00;
      endcase
   endfunction

   // Reference model: mSlot is the position within the 3-cycle instruction
   // (0 none, 1..3 cycle of instruction, 4 parked for Step).
   int         mSlot = 0;
   logic [3:0] mPc = 4'd0;
   logic [7:0] mWord = 8'd0;
   logic       mHalted = 1'b0;

   always @(posedge MainClock) begin
      if (Clear) begin
         mSlot <= 0; mPc <= 4'd0; mWord <= 8'd0; mHalted <= 1'b0;
      end else if (!mHalted) begin
         case (mSlot)
            0: if (seqBus.Run) mSlot <= 1;
            1: begin mWord <= prog[mPc]; mSlot <= 2; end
            2: begin mPc <= mPc + 4'd1; mSlot <= 3; end
            3: begin
               if (mWord[7:4] == 4'hA) mPc <= mWord[3:0];
               if (mWord[7:4] == 4'hF) begin mHalted <= 1'b1; mSlot <= 0; end
`ifdef SEQ_STEP_EN
               else mSlot <= 4;
`else
               else mSlot <= seqBus.Run ? 1 : 0;
`endif
            end
`ifdef SEQ_STEP_EN
            4: if (!seqBus.Run) mSlot <= 0; else if (seqBus.Step) mSlot <= 1;
`endif
            default: mSlot <= 0;
         endcase
      end
   end

   logic [5:0] expStrobe;
   logic [3:0] cOp;
   always @(negedge MainClock) begin
      #3;
      if (checkEn) begin
         cOp = mWord[7:4];
         expStrobe = (mSlot == 3) ? strobeFor(cOp) : 6'b0;
         expStrobe[3] = expStrobe[3] | Clear;
         expStrobe[2] = expStrobe[2] | Clear;
         check("strobes", {seqBus.LatchA, seqBus.LatchB, seqBus.ClearA, seqBus.ClearB,
                           seqBus.LatchOut, seqBus.IllegalOp}, expStrobe);
         check("Pc", seqBus.Pc, mPc);
         check("Halted", seqBus.Halted, mHalted | ((mSlot == 3) && (cOp == 4'hF)));
         if (mSlot == 2 || mSlot == 3) begin
            check("Imm", seqBus.Imm, mWord[3:0]);
            check("AluOp", seqBus.AluOp, aluFor(cOp));
            check("DataSel", seqBus.DataSel, cOp == 4'h9);
         end
      end
   end

   task automatic goCycle(input int n);
      repeat (n - cur) @(posedge MainClock);
      @(negedge MainClock);
      #1;
      cur = n;
   endtask

   task automatic clearProg();
      for (int i = 0; i < 16; i++) prog[i] = 8'h00;
   endtask

   // Leaves the bench one cycle after the reset edge with Clear still high.
   task automatic resetSeq();
      Clear = 1'b1;
      seqBus.Run = 1'b0;
      @(posedge MainClock);
      @(negedge MainClock);
      #1;
   endtask

   task automatic startRun();
      Clear = 1'b0;
      seqBus.Run = 1'b1;
      cur = 0;
   endtask

   initial begin
      seqBus.Run = 1'b0;
`ifdef SEQ_STEP_EN
      seqBus.Step = 1'b0;
`endif
      clearProg();
      prog[0] = 8'h13; prog[1] = 8'h25; prog[2] = 8'h30; prog[3] = 8'hF0;
      resetSeq();
      checkEn = 1'b1;
      check("rst ClearA", seqBus.ClearA, 1);
      check("rst ClearB", seqBus.ClearB, 1);
      check("rst Pc", seqBus.Pc, 0);
      check("rst Halted", seqBus.Halted, 0);
      check("rst LatchA", seqBus.LatchA, 0);
      check("rst Imm", seqBus.Imm, 0);
      check("rst AluOp", seqBus.AluOp, 0);
      check("rst DataSel", seqBus.DataSel, 0);

`ifdef SEQ_STEP_EN
      startRun();
      goCycle(1);  check("step ClearA off", seqBus.ClearA, 0);
      goCycle(3);  check("step LatchA", seqBus.LatchA, 1);
      goCycle(10); check("step parked Pc", seqBus.Pc, 1);
                   check("step parked LatchB", seqBus.LatchB, 0);
      seqBus.Step = 1'b1;
      goCycle(11); seqBus.Step = 1'b0;
      goCycle(13); check("step LatchB", seqBus.LatchB, 1);
                   check("step Imm", seqBus.Imm, 5);
      goCycle(20); check("step parked again Pc", seqBus.Pc, 2);
                   check("step Halted early", seqBus.Halted, 0);
      seqBus.Step = 1'b1;
      goCycle(23); check("step Halted", seqBus.Halted, 1);
      seqBus.Step = 1'b0;
`else
      startRun();
      goCycle(1);  check("p1 ClearA off", seqBus.ClearA, 0);
      goCycle(3);  check("p1 LatchA", seqBus.LatchA, 1);
                   check("p1 Imm3", seqBus.Imm, 3);
                   check("p1 Pc1", seqBus.Pc, 1);
      goCycle(6);  check("p1 LatchB", seqBus.LatchB, 1);
                   check("p1 Imm5", seqBus.Imm, 5);
      goCycle(9);  check("p1 LatchOut", seqBus.LatchOut, 1);
                   check("p1 AluOp", seqBus.AluOp, 0);
      goCycle(12); check("p1 Halted12", seqBus.Halted, 1);
      goCycle(13); check("p1 Halted13", seqBus.Halted, 1);
                   check("p1 Pc4", seqBus.Pc, 4);
      goCycle(20); check("p1 frozen Pc", seqBus.Pc, 4);
                   check("p1 still Halted", seqBus.Halted, 1);

      clearProg();
      prog[2] = 8'hAE;
      resetSeq();
      startRun();
      goCycle(9);  check("jmp exec Pc", seqBus.Pc, 3);
      goCycle(10); check("jmp target Pc", seqBus.Pc, 14);
      goCycle(13); check("jmp Pc15", seqBus.Pc, 15);
      goCycle(16); check("jmp wrap Pc", seqBus.Pc, 0);
      seqBus.Run = 1'b0;
      goCycle(22); check("jmp idle Pc", seqBus.Pc, 1);

      clearProg();
      prog[0] = 8'hC0; prog[1] = 8'hF0;
      resetSeq();
      startRun();
      goCycle(3);  check("ill pulse", seqBus.IllegalOp, 1);
                   check("ill no strobe", {seqBus.LatchA, seqBus.LatchB, seqBus.ClearA,
                                           seqBus.ClearB, seqBus.LatchOut}, 0);
                   check("ill Pc", seqBus.Pc, 1);
      goCycle(4);  check("ill single", seqBus.IllegalOp, 0);
      goCycle(6);  check("ill then HLT", seqBus.Halted, 1);

      clearProg();
      prog[0] = 8'h27; prog[1] = 8'h11;
      resetSeq();
      startRun();
      goCycle(2);  seqBus.Run = 1'b0;
      goCycle(3);  check("rundrop LatchB", seqBus.LatchB, 1);
                   check("rundrop Imm", seqBus.Imm, 7);
      goCycle(8);  check("rundrop Pc", seqBus.Pc, 1);
                   check("rundrop no LatchA", seqBus.LatchA, 0);

      clearProg();
      prog[0] = 8'h19;
      resetSeq();
      startRun();
      goCycle(2);  Clear = 1'b1;
      goCycle(3);  check("abort LatchA", seqBus.LatchA, 0);
                   check("abort Pc", seqBus.Pc, 0);
                   check("abort ClearA", seqBus.ClearA, 1);
      Clear = 1'b0; seqBus.Run = 1'b0;
      goCycle(6);  check("abort idle LatchA", seqBus.LatchA, 0);
                   check("abort idle Pc", seqBus.Pc, 0);

      clearProg();
      prog[0] = 8'h13; prog[1] = 8'h22; prog[2] = 8'h30; prog[3] = 8'h40;
      prog[4] = 8'h50; prog[5] = 8'h60; prog[6] = 8'h70; prog[7] = 8'h80;
      prog[8] = 8'h90; prog[9] = 8'hB0; prog[10] = 8'hD0; prog[11] = 8'hE0;
      prog[12] = 8'hF0;
      resetSeq();
      startRun();
      goCycle(12); check("all SUB LatchOut", seqBus.LatchOut, 1);
                   check("all SUB AluOp", seqBus.AluOp, 1);
      goCycle(15); check("all AND AluOp", seqBus.AluOp, 2);
      goCycle(18); check("all OR AluOp", seqBus.AluOp, 3);
      goCycle(21); check("all CLRA", seqBus.ClearA, 1);
      goCycle(24); check("all CLRB", seqBus.ClearB, 1);
      goCycle(26); check("all MVA decode DataSel", seqBus.DataSel, 1);
      goCycle(27); check("all MVA LatchA", seqBus.LatchA, 1);
                   check("all MVA DataSel", seqBus.DataSel, 1);
                   check("all MVA AluOp", seqBus.AluOp, 0);
      goCycle(30); check("all opB illegal", seqBus.IllegalOp, 1);
      goCycle(39); check("all Halted", seqBus.Halted, 1);
                   check("all Pc", seqBus.Pc, 13);
`endif
      goCycle(cur + 3);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
